// File: rtl/lut_mult_pkg.sv
// Shared types and constants for the LUT-based signed-digit multiplier datapath.
package lut_mult_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUILD = 2'd1,
        ACCUM = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DIGIT_W     = 4;
    localparam int MAG_MAX     = 8;
    localparam int TABLE_DEPTH = 9;

    function automatic logic digit_legal(input logic [DIGIT_W-1:0] mag);
        return (mag <= DIGIT_W'(MAG_MAX));
    endfunction

endpackage

// File: rtl/lut_multiple_table.sv
// Table of multiples T[k] = A*k for k = 0..8, filled one entry per cycle by repeated addition.
module lut_multiple_table
    import lut_mult_pkg::*;
#(
    parameter int A_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic [A_W-1:0]        i_a,
    input  logic                  i_build_en,
    input  logic [DIGIT_W-1:0]    i_rd_mag,
    output logic signed [A_W+3:0] o_rd_data,
    output logic                  o_build_last,
    output logic                  o_built
);

    localparam int E_W = A_W + 4;
    localparam logic [DIGIT_W-1:0] LAST_K = DIGIT_W'(TABLE_DEPTH - 1);

    logic signed [E_W-1:0]   r_tbl [TABLE_DEPTH];
    logic [DIGIT_W-1:0]      r_k;
    logic                    r_built;
    logic signed [A_W-1:0]   w_a_s;
    logic [DIGIT_W-1:0]      w_k_prev;

    assign w_a_s    = i_a;
    assign w_k_prev = r_k - DIGIT_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_k     <= '0;
            r_built <= 1'b0;
            for (int i = 0; i < TABLE_DEPTH; i++) begin
                r_tbl[i] <= '0;
            end
        end else if (i_load) begin
            r_tbl[0] <= '0;
            r_tbl[1] <= E_W'(w_a_s);
            r_k      <= DIGIT_W'(2);
            r_built  <= 1'b0;
        end else if (i_build_en && !r_built) begin
            r_tbl[r_k] <= r_tbl[w_k_prev] + r_tbl[1];
            if (r_k == LAST_K) begin
                r_built <= 1'b1;
            end else begin
                r_k <= r_k + DIGIT_W'(1);
            end
        end
    end

    // Illegal magnitudes read as zero so they add nothing to the accumulator.
    always_comb begin
        o_rd_data = '0;
        if (digit_legal(i_rd_mag)) begin
            o_rd_data = r_tbl[i_rd_mag];
        end
    end

    assign o_build_last = i_build_en && !r_built && (r_k == LAST_K);
    assign o_built      = r_built;

endmodule

// File: rtl/lut_digit_accumulator.sv
// Signed multiplicand times a stream of recoded radix-16 digits, LSD first, via a multiple table.
//
// state | meaning
// IDLE  | waiting for multiplicand A (start_ready=1)
// BUILD | filling T[2..8], one entry per cycle
// ACCUM | accepting digits, accumulating shifted multiples (dig_ready=1)
// DONE  | product held on p_out/p_err until p_ready
module lut_digit_accumulator
    import lut_mult_pkg::*;
#(
    parameter int A_W      = 8,
    parameter int N_DIGITS = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_valid,
    output logic                      start_ready,
    input  logic [A_W-1:0]            a_in,
    input  logic                      dig_valid,
    output logic                      dig_ready,
    input  logic                      dig_sign,
    input  logic [DIGIT_W-1:0]        dig_mag,
    output logic                      p_valid,
    input  logic                      p_ready,
    output logic [A_W+4*N_DIGITS-1:0] p_out,
    output logic                      p_err
);

    localparam int P_W   = A_W + 4 * N_DIGITS;
    localparam int E_W   = A_W + 4;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

    state_t                r_state;
    logic signed [P_W-1:0] r_acc;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_err;

    logic                  w_start_xfer;
    logic                  w_dig_xfer;
    logic                  w_p_xfer;
    logic                  w_build_last;
    logic                  w_built;
    logic signed [E_W-1:0] w_t;
    logic signed [E_W-1:0] w_m;
    logic signed [P_W-1:0] w_m_ext;
    logic signed [P_W-1:0] w_term;
    logic [IDX_W+1:0]      w_shamt;

    // Ready/valid come from the state register only, never from the incoming valids.
    assign start_ready = (r_state == IDLE);
    assign dig_ready   = (r_state == ACCUM);
    assign p_valid     = (r_state == DONE);
    assign p_out       = r_acc;
    assign p_err       = r_err;

    assign w_start_xfer = start_valid && start_ready;
    assign w_dig_xfer   = dig_valid && dig_ready;
    assign w_p_xfer     = p_valid && p_ready;

    lut_multiple_table #(
        .A_W (A_W)
    ) u_table (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load       (w_start_xfer),
        .i_a          (a_in),
        .i_build_en   (r_state == BUILD),
        .i_rd_mag     (dig_mag),
        .o_rd_data    (w_t),
        .o_build_last (w_build_last),
        .o_built      (w_built)
    );

    // |T| <= 8*2^(A_W-1), so negation never overflows the E_W-bit entry.
    assign w_m     = dig_sign ? -w_t : w_t;
    assign w_m_ext = P_W'(w_m);
    assign w_shamt = {r_idx, 2'b00};
    assign w_term  = w_m_ext <<< w_shamt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_idx   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start_xfer) begin
                        r_acc   <= '0;
                        r_idx   <= '0;
                        r_err   <= 1'b0;
                        r_state <= BUILD;
                    end
                end
                BUILD: begin
                    if (w_build_last || w_built) begin
                        r_state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (w_dig_xfer) begin
                        r_acc <= r_acc + w_term;
                        if (!digit_legal(dig_mag)) begin
                            r_err <= 1'b1;
                        end
                        if (r_idx == LAST_IDX) begin
                            r_state <= DONE;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (w_p_xfer) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lut_digit_accumulator.sv
// Directed self-checking bench for lut_digit_accumulator with hand-computed products.
module tb_lut_digit_accumulator;

    localparam int A_W      = 8;
    localparam int N_DIGITS = 2;
    localparam int P_W      = A_W + 4 * N_DIGITS;

    logic           clk;
    logic           rst_n;
    logic           start_valid;
    logic           start_ready;
    logic [A_W-1:0] a_in;
    logic           dig_valid;
    logic           dig_ready;
    logic           dig_sign;
    logic [3:0]     dig_mag;
    logic           p_valid;
    logic           p_ready;
    logic [P_W-1:0] p_out;
    logic           p_err;

    int n_checks;
    int n_errors;

    lut_digit_accumulator #(
        .A_W      (A_W),
        .N_DIGITS (N_DIGITS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a_in        (a_in),
        .dig_valid   (dig_valid),
        .dig_ready   (dig_ready),
        .dig_sign    (dig_sign),
        .dig_mag     (dig_mag),
        .p_valid     (p_valid),
        .p_ready     (p_ready),
        .p_out       (p_out),
        .p_err       (p_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [A_W-1:0] a, input string tag);
        logic ok;
        ok          = 1'b0;
        a_in        = a;
        start_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (start_ready === 1'b1) begin
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        start_valid = 1'b0;
        check({tag, "_start_accept"}, 32'(ok), 1);
    endtask

    task automatic send_digit(input logic s, input logic [3:0] m, input string tag);
        logic ok;
        ok        = 1'b0;
        dig_sign  = s;
        dig_mag   = m;
        dig_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (dig_ready === 1'b1) begin
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        dig_valid = 1'b0;
        check({tag, "_dig_accept"}, 32'(ok), 1);
    endtask

    task automatic take_product(input int exp_p, input logic exp_err, input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (p_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check({tag, "_p_valid"}, 32'(ok), 1);
        check({tag, "_p_out"}, $signed(p_out), exp_p);
        check({tag, "_p_err"}, 32'(p_err), 32'(exp_err));
        p_ready = 1'b1;
        tick();
        p_ready = 1'b0;
        check({tag, "_p_valid_drop"}, 32'(p_valid), 0);
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        start_valid = 1'b0;
        a_in        = '0;
        dig_valid   = 1'b0;
        dig_sign    = 1'b0;
        dig_mag     = '0;
        p_ready     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        check("rst_start_ready", 32'(start_ready), 1);
        check("rst_dig_ready", 32'(dig_ready), 0);
        check("rst_p_valid", 32'(p_valid), 0);
        check("rst_p_out", $signed(p_out), 0);
        check("rst_p_err", 32'(p_err), 0);

        // A=5, digits +3,+2; dig_valid held high through BUILD.
        do_start(8'sd5, "op1");
        dig_valid = 1'b1;
        dig_sign  = 1'b0;
        dig_mag   = 4'd3;
        for (int j = 1; j <= 7; j++) begin
            check("op1_build_dig_ready_low", 32'(dig_ready), 0);
            tick();
        end
        check("op1_dig_ready_after_build", 32'(dig_ready), 1);
        tick();
        dig_mag = 4'd2;
        check("op1_second_digit_ready", 32'(dig_ready), 1);
        check("op1_p_valid_before_last", 32'(p_valid), 0);
        tick();
        dig_valid = 1'b0;
        check("op1_p_valid_latency", 32'(p_valid), 1);
        take_product(175, 1'b0, "op1");
        check("op1_start_ready_back", 32'(start_ready), 1);

        // A=-128, digits -8,-8 -> B=-136.
        do_start(8'h80, "op2");
        send_digit(1'b1, 4'd8, "op2_d0");
        send_digit(1'b1, 4'd8, "op2_d1");
        take_product(17408, 1'b0, "op2");

        // A=7, digits (-0),(-1) -> B=-16.
        do_start(8'sd7, "op3");
        send_digit(1'b1, 4'd0, "op3_d0");
        send_digit(1'b1, 4'd1, "op3_d1");
        take_product(-112, 1'b0, "op3");

        // A=3, digits +8,+1 with a 4-cycle gap, then consumer stalls 5 cycles.
        do_start(8'sd3, "op4");
        send_digit(1'b0, 4'd8, "op4_d0");
        for (int j = 0; j < 4; j++) begin
            check("op4_gap_dig_ready", 32'(dig_ready), 1);
            check("op4_gap_p_valid", 32'(p_valid), 0);
            tick();
        end
        send_digit(1'b0, 4'd1, "op4_d1");
        tick();
        for (int j = 0; j < 5; j++) begin
            start_valid = (j % 2 == 0);
            a_in        = 8'sd100;
            check("op4_hold_p_valid", 32'(p_valid), 1);
            check("op4_hold_p_out", $signed(p_out), 72);
            check("op4_hold_start_ready", 32'(start_ready), 0);
            tick();
        end
        start_valid = 1'b0;
        take_product(72, 1'b0, "op4");

        // A=2, illegal magnitude 9 then +1 -> 32 with error; next op clears it.
        do_start(8'sd2, "op5");
        send_digit(1'b0, 4'd9, "op5_d0");
        send_digit(1'b0, 4'd1, "op5_d1");
        take_product(32, 1'b1, "op5");
        do_start(8'sd2, "op6");
        send_digit(1'b0, 4'd1, "op6_d0");
        send_digit(1'b0, 4'd1, "op6_d1");
        take_product(34, 1'b0, "op6");

        // Reset mid-ACCUM, then a fresh A=-1 with +1,+1 -> -17.
        do_start(8'sd9, "op7");
        send_digit(1'b0, 4'd5, "op7_d0");
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_start_ready", 32'(start_ready), 1);
        check("midrst_dig_ready", 32'(dig_ready), 0);
        check("midrst_p_valid", 32'(p_valid), 0);
        check("midrst_p_out", $signed(p_out), 0);
        do_start(8'hFF, "op8");
        send_digit(1'b0, 4'd1, "op8_d0");
        send_digit(1'b0, 4'd1, "op8_d1");
        take_product(-17, 1'b0, "op8");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/lut_digit_accumulator.md
Name: lut_digit_accumulator

Overview:
- Downstream consumer of the signed-digit input recoder in the LUT multiplier datapath.
- Takes a signed multiplicand A, then a stream of N_DIGITS recoded multiplier digits, least-significant first. Each digit is {sign, magnitude 0..8}.
- Builds a 9-entry table of multiples A*k (k=0..8) sequentially, then looks up, negates, shifts and accumulates one digit per beat.
- Emits the signed product over a valid/ready handshake.

Parameters:
- A_W, 8, multiplicand width (two's complement).
- N_DIGITS, 2, number of radix-16 digits per multiplier operand.
- P_W, A_W+4*N_DIGITS, product width (two's complement; derived, not to be overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start_valid  in  1  operand A offered.
- start_ready  out  1  block can accept A (IDLE only).
- a_in  in  A_W  signed multiplicand.
- dig_valid  in  1  digit offered.
- dig_ready  out  1  block accepts digit (ACCUM only).
- dig_sign  in  1  1 = negative digit.
- dig_mag  in  4  digit magnitude; legal range 0..8.
- p_valid  out  1  product available.
- p_ready  in  1  consumer takes product.
- p_out  out  P_W  signed product A*sum(d_i*16^i).
- p_err  out  1  an illegal magnitude (9..15) occurred in this operation; qualified by p_valid.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low. While rst_n=0 at a clock edge:
  - state <= IDLE; accumulator, digit counter, build counter and error flag <= 0.
  - Resulting outputs: start_ready=1, dig_ready=0, p_valid=0, p_out=0, p_err=0.
  - Reset applies from any state, including mid-BUILD or mid-ACCUM. Partial results are discarded.
- Handshake rule: a transfer occurs on an edge where valid and ready are both 1. The ready outputs are decoded from the state register only; there is no combinational path from valid to ready.
- IDLE: start_ready=1.
  - On a start transfer: latch a_in, set T[0]=0 and T[1]=sext(a_in), clear accumulator, digit index and err; go to BUILD.
- BUILD: 7 cycles. Each cycle writes T[k] = T[k-1] + T[1] for k=2..8, in order. Then go to ACCUM.
  - Table entries are A_W+4 bits signed.
  - With the start transfer at edge E, dig_ready first reads 1 in the cycle after edge E+7.
- ACCUM: dig_ready=1.
  - On each digit transfer with index i (0..N_DIGITS-1):
    - m = dig_sign ? -T[mag] : T[mag], computed in A_W+4 bits.
    - acc += sext_P_W(m) << 4*i.
    - Sign with mag=0 contributes 0.
  - mag 9..15: the digit contributes 0 and err is set; processing continues.
  - Gaps in dig_valid stall the block with no state change.
  - After digit N_DIGITS-1 is accepted: go to DONE on the same edge.
- DONE: p_valid=1; p_out=acc; p_err=err. Both are held stable until a transfer on p_ready.
  - On that transfer: go to IDLE, p_valid=0.
  - start_valid is ignored outside IDLE; dig_valid is ignored outside ACCUM.
- Latency: with digits back-to-back, p_valid rises 1 cycle after the edge accepting the last digit.
- Width proof: |A| ≤ 2^(A_W-1) and |B| ≤ 8*(16^N-1)/15, so |A*B| < 2^(P_W-1). No overflow or saturation logic is needed.
- No back-to-back overlap: the next start is accepted only in IDLE.

Decomposition:
- Package lut_mult_pkg holds:
  - state enum {IDLE, BUILD, ACCUM, DONE};
  - DIGIT_W=4, MAG_MAX=8, TABLE_DEPTH=9;
  - helper function digit_legal(mag).
- Sub-module lut_multiple_table: owns T[0..8], the build counter and the build-done flag; provides the combinational read port T[mag].
- The accumulator, FSM and handshakes live in the top level.

Test Plan:
- A=5; digits (+3),(+2) back-to-back → p_out=175, p_err=0. p_valid is asserted exactly 1 cycle after the second digit is accepted.
- A=-128; digits (-8),(-8) → B=-136, p_out=17408. A=7; digits (sign=1,mag=0),(-1) → p_out=-112.
- A=3; dig_valid gaps of 0,4,1 cycles; then p_ready held low for 5 cycles → p_out=... with A=3, digits (+8),(+1): p_out=72. p_out and p_valid stay constant while p_ready=0; start_valid pulses in that window are not accepted.
- A=2; digits (mag=9),(+1) → p_out=32, p_err=1. The next operation with legal digits returns p_err=0.
- Assert rst_n=0 for one edge after one digit is accepted in ACCUM → next cycle start_ready=1, dig_ready=0, p_valid=0. A fresh operation, A=-1 with digits (+1),(+1), gives -17.
- dig_valid=1 during BUILD → dig_ready=0 for the whole BUILD window. The first digit is accepted exactly 8 edges after the start transfer.
